// File: rtl/line_buffer_ntap.sv
// line_buffer_ntap: stores the last NUM_LINES rows in rotating RAM banks and
// presents a vertically aligned column of NUM_LINES+1 taps per input pixel.
module line_buffer_ntap #(
    parameter int DATA_W    = 10,
    parameter int ADDR_W    = 12,
    parameter int NUM_LINES = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [ADDR_W-1:0]               line_len,
    input  logic                            in_valid,
    input  logic                            in_sof,
    input  logic                            in_eol,
    input  logic [DATA_W-1:0]               in_data,
    output logic                            out_valid,
    output logic                            out_sof,
    output logic                            out_eol,
    output logic [ADDR_W-1:0]               out_col,
    output logic [(NUM_LINES+1)*DATA_W-1:0] out_taps,
    output logic                            out_rows_ok,
    output logic                            err_len
);
    localparam int SEL_W = NUM_LINES > 1 ? $clog2(NUM_LINES) : 1;
    localparam int RS_W  = $clog2(NUM_LINES + 1);

    logic [DATA_W-1:0] mem [NUM_LINES][2**ADDR_W];
    logic [DATA_W-1:0] rd_q [NUM_LINES];

    logic [ADDR_W-1:0] col_q, col_d, len_q, len_d, ocol_q, ocol_d;
    logic [SEL_W-1:0]  sel_q, sel_d, osel_q, osel_d;
    logic [RS_W-1:0]   rows_q, rows_d, orows_q, orows_d;
    logic              err_q, err_d, valid_q, valid_d, sof_q, sof_d, eol_q, eol_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic [ADDR_W-1:0] col_eff, len_eff;
    logic [SEL_W-1:0]  sel_eff, tap_bank;
    logic [RS_W-1:0]   rows_eff;
    logic              by_len, line_end;

    // A start-of-frame pixel sees cleared counters as if they were already reset.
    always_comb begin
        col_eff  = in_sof ? '0 : col_q;
        sel_eff  = in_sof ? '0 : sel_q;
        rows_eff = in_sof ? '0 : rows_q;
        len_eff  = in_sof ? line_len : len_q;
        by_len   = col_eff == ADDR_W'(len_eff - 1'b1);
        line_end = in_eol | by_len;
        col_d    = in_valid ? (line_end ? '0 : col_eff + 1'b1) : col_q;
        sel_d    = in_valid ? (line_end ? (sel_eff == SEL_W'(NUM_LINES - 1) ? '0 : sel_eff + 1'b1) : sel_eff) : sel_q;
        rows_d   = in_valid ? (line_end && rows_eff != RS_W'(NUM_LINES) ? rows_eff + 1'b1 : rows_eff) : rows_q;
        len_d    = in_valid && in_sof ? line_len : len_q;
        err_d    = in_valid ? ((in_sof ? 1'b0 : err_q) | (in_eol ^ by_len)) : err_q;
        valid_d  = in_valid;
        sof_d    = in_valid & in_sof;
        eol_d    = in_valid & line_end;
        ocol_d   = in_valid ? col_eff : ocol_q;
        osel_d   = in_valid ? sel_eff : osel_q;
        orows_d  = in_valid ? rows_eff : orows_q;
        data_d   = in_valid ? in_data : data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q   <= '0;
            sel_q   <= '0;
            rows_q  <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            ocol_q  <= '0;
            osel_q  <= '0;
            orows_q <= '0;
            data_q  <= '0;
        end else begin
            col_q   <= col_d;
            sel_q   <= sel_d;
            rows_q  <= rows_d;
            len_q   <= len_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
            ocol_q  <= ocol_d;
            osel_q  <= osel_d;
            orows_q <= orows_d;
            data_q  <= data_d;
        end
    end

    // Read-first RAM: the oldest bank returns the row being overwritten.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            mem[sel_eff][col_eff] <= in_data;
            for (int b = 0; b < NUM_LINES; b++) rd_q[b] <= mem[b][col_eff];
        end
    end

    always_comb begin
        out_taps = '0;
        tap_bank = '0;
        out_taps[DATA_W-1:0] = data_q;
        for (int k = 1; k <= NUM_LINES; k++) begin
            tap_bank = SEL_W'((int'(osel_q) + NUM_LINES - k) % NUM_LINES);
            out_taps[k*DATA_W +: DATA_W] = int'(orows_q) < k ? '0 : rd_q[tap_bank];
        end
    end

    assign out_valid   = valid_q;
    assign out_sof     = sof_q;
    assign out_eol     = eol_q;
    assign out_col     = ocol_q;
    assign out_rows_ok = orows_q == RS_W'(NUM_LINES);
    assign err_len     = err_q;
endmodule

// File: tb/tb_line_buffer_ntap.sv
// tb_line_buffer_ntap: randomized and directed stimulus against a row-history
// reference model of the line buffer.
module tb_line_buffer_ntap;
    localparam int DW = 10;
    localparam int AW = 5;
    localparam int N  = 2;
    localparam int TW = (N + 1) * DW;
    localparam int MAXC = 2**AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] line_len = '0;
    logic          in_valid = 1'b0, in_sof = 1'b0, in_eol = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_valid, out_sof, out_eol, out_rows_ok, err_len;
    logic [AW-1:0] out_col;
    logic [TW-1:0] out_taps;

    line_buffer_ntap #(.DATA_W(DW), .ADDR_W(AW), .NUM_LINES(N)) dut (
        .clk(clk), .rst_n(rst_n), .line_len(line_len), .in_valid(in_valid),
        .in_sof(in_sof), .in_eol(in_eol), .in_data(in_data),
        .out_valid(out_valid), .out_sof(out_sof), .out_eol(out_eol),
        .out_col(out_col), .out_taps(out_taps), .out_rows_ok(out_rows_ok),
        .err_len(err_len)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: each row of the current frame is numbered; row r lives in slot r mod N.
    logic [DW-1:0] hist [N][MAXC];
    int m_col = 0, m_line = 0, m_len = 0;
    bit m_err = 0;

    task automatic model_reset();
        m_col = 0; m_line = 0; m_len = 0; m_err = 0;
    endtask

    task automatic pix(input bit v, input bit sof, input bit eol, input int d, input int len);
        bit e_valid, e_sof, e_eol, e_ok, by_len, lend;
        int e_col, l, rs;
        logic [TW-1:0] e_taps;
        in_valid = v; in_sof = sof; in_eol = eol; in_data = DW'(d); line_len = AW'(len);
        e_valid = v; e_sof = 0; e_eol = 0; e_ok = 0; e_col = 0; e_taps = '0;
        if (v) begin
            if (sof) begin m_col = 0; m_line = 0; m_len = len; m_err = 0; end
            l = m_len == 0 ? MAXC : m_len;
            by_len = m_col == l - 1;
            lend = eol || by_len;
            if (eol != by_len) m_err = 1;
            rs = m_line < N ? m_line : N;
            e_taps[DW-1:0] = DW'(d);
            for (int k = 1; k <= N; k++)
                if (rs >= k) e_taps[k*DW +: DW] = hist[(m_line - k) % N][m_col];
            hist[m_line % N][m_col] = DW'(d);
            e_sof = sof; e_eol = lend; e_col = m_col; e_ok = rs == N;
            m_col = lend ? 0 : m_col + 1;
            if (lend) m_line++;
        end
        @(posedge clk); #1;
        check("valid", out_valid, e_valid);
        check("sof", out_sof, e_sof);
        check("eol", out_eol, e_eol);
        check("err_len", err_len, m_err);
        if (e_valid) begin
            check("col", out_col, e_col);
            check("taps", out_taps, e_taps);
            check("rows_ok", out_rows_ok, e_ok);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_sof"}, out_sof, 0);
        check({tag, "_eol"}, out_eol, 0);
        check({tag, "_col"}, out_col, 0);
        check({tag, "_taps"}, out_taps, 0);
        check({tag, "_ok"}, out_rows_ok, 0);
        check({tag, "_err"}, err_len, 0);
    endtask

    task automatic ramp(input bit bubbles, input int rows);
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < 8; c++) begin
                pix(1, r == 0 && c == 0, c == 7, r * 16 + c, 8);
                if (r == 2 && c == 3) check("ramp_r2c3", out_taps, 30'h304C23);
                if (r == 2 && c == 0) check("ok_rise", out_rows_ok, 1);
                if (r == 1 && c == 7) check("ok_low", out_rows_ok, 0);
                if (bubbles) pix(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom, 8);
            end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        ramp(0, 4);
        ramp(1, 4);
        // length mismatch: eol at col 5 with line_len 8
        for (int c = 0; c < 6; c++) pix(1, c == 0, c == 5, 100 + c, 8);
        check("mis_eol", out_eol, 1);
        check("mis_err", err_len, 1);
        for (int c = 0; c < 8; c++) pix(1, 0, 0, 200 + c, 8);
        check("len_end", out_eol, 1);
        pix(1, 1, 0, 7, 8);
        check("err_clr", err_len, 0);
        // back-to-back frames with a restart mid-row
        for (int c = 1; c < 12; c++) pix(1, 0, c == 7, 300 + c, 8);
        pix(1, 1, 0, 400, 8);
        check("b2b_ok", out_rows_ok, 0);
        check("b2b_col", out_col, 0);
        pix(1, 1, 1, 555, 8);
        check("one_px_eol", out_eol, 1);
        for (int c = 0; c < 3; c++) pix(1, 0, 0, 600 + c, 8);
        // full-width line with line_len = 0
        for (int c = 0; c < 70; c++) begin
            pix(1, c == 0, 0, $urandom, 0);
            if (c == 31) begin
                check("wrap_eol", out_eol, 1);
                check("wrap_col", out_col, 31);
            end
        end
        // async reset in the middle of row 3
        ramp(0, 3);
        for (int c = 0; c < 4; c++) pix(1, 0, 0, 48 + c, 8);
        #2 rst_n = 1'b0;
        in_valid = 1'b0;
        #1 check_zero("arst");
        model_reset();
        @(posedge clk); #1 rst_n = 1'b1;
        pix(0, 0, 0, 0, 8);
        for (int c = 0; c < 40; c++) pix(1, 0, 0, 900 + c, 8);
        // random traffic
        for (int i = 0; i < 600; i++)
            pix($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 1023), $urandom_range(0, 9));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/line_buffer_ntap.md
# line_buffer_ntap

Parametrised multi-line buffer for the Bayer-to-RGB pipeline. It stores the last NUM_LINES rows of an incoming pixel stream in rotating dual-port RAM banks. For every input pixel it presents a vertically aligned column of NUM_LINES+1 taps (current row plus the rows above), together with frame/line markers and border masking. It sits between the sensor input stage and the demosaic kernel, replacing single-row buffering with a generic N-row window.

## Interface
- DATA_W, 10, pixel width in bits
- ADDR_W, 12, column address width; max line length 2^ADDR_W
- NUM_LINES, 2, number of stored rows (legal 1..4)
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- line_len  in  ADDR_W  active pixels per line; sampled on the pixel with in_sof; 0 means 2^ADDR_W
- in_valid  in  1  input pixel qualifier
- in_sof  in  1  first pixel of frame; meaningful only with in_valid
- in_eol  in  1  last pixel of line; meaningful only with in_valid
- in_data  in  DATA_W  pixel
- out_valid  out  1  output column qualifier
- out_sof  out  1  delayed in_sof
- out_eol  out  1  line end, either in_eol or the length-terminated end
- out_col  out  ADDR_W  column index of output column
- out_taps  out  (NUM_LINES+1)*DATA_W  tap k at bits [k*DATA_W +: DATA_W]; k=0 current row, k=j is j rows above
- out_rows_ok  out  1  all NUM_LINES stored rows belong to the current frame
- err_len  out  1  sticky line-length mismatch flag; cleared by next in_sof

## Operation
- Storage: NUM_LINES banks, each 2^ADDR_W x DATA_W, simple dual-port. Synchronous write. Registered, read-first read: a same-address read and write in one cycle returns the old word.
- col counter: on in_valid, col is the address of the current pixel. It increments after each pixel and returns to 0 after line end. A pixel with in_sof forces its own address to 0.
- Line end: the pixel with in_eol, or the pixel at col == line_len_q-1, whichever comes first. If exactly one of these conditions holds on a pixel, err_len is set.
- wr_sel (0..NUM_LINES-1): the bank holding the oldest row. Each pixel is written to bank wr_sel at col, while every bank is read at col in the same cycle. At line end, wr_sel advances by 1 mod NUM_LINES.
- Tap mapping: tap k (k>=1) comes from bank (wr_sel - k) mod NUM_LINES, using the wr_sel that was registered with the pixel.
- rows_seen: counts completed lines and saturates at NUM_LINES. Tap k is forced to 0 while rows_seen < k (top border masking). out_rows_ok = (rows_seen == NUM_LINES).
- in_sof (with in_valid): loads line_len_q, and zeroes col, wr_sel, rows_seen and err_len before that pixel is processed. The pixel itself is handled as column 0 of row 0.
- in_valid=0: no write, no counter change, out_valid=0 next cycle.
- in_sof and in_eol on the same pixel: legal one-pixel line. The line ends, rows_seen becomes 1, and wr_sel becomes 1 mod NUM_LINES.

## Timing
- Latency 1 cycle: a pixel at cycle t produces out_valid, out_taps, out_col, out_sof and out_eol at t+1.
- Full throughput: one pixel per cycle with no gaps required. Arbitrary bubbles are allowed.
- Reset values (async, rst_n=0): out_valid=0, out_sof=0, out_eol=0, out_col=0, out_taps=0, out_rows_ok=0, err_len=0. Internal state: col=0, wr_sel=0, rows_seen=0, line_len_q=0.
- RAM is not cleared by reset. Stale contents are hidden by the rows_seen masking.
- Reset mid-line: the next output is valid only after a new in_valid pixel. Taps 1..NUM_LINES stay masked until new lines complete.
- Pixels before the first in_sof after reset are processed with line_len_q=0, i.e. a line length of 2^ADDR_W.
- Wrap: with line_len=0, col runs 0..2^ADDR_W-1 and ends the line at the max address without overflow.

## Test plan
- Ramp frame with NUM_LINES=2, line_len=8, pixel=row*16+col over 4 rows -> on row 2 col 3, out_taps = {0x03, 0x13, 0x23} (tap2, tap1, tap0); out_rows_ok first rises on row 2 col 0.
- Border masking: row 0 -> taps 1,2 = 0; row 1 -> tap1 = row-0 data, tap2 = 0.
- Bubbles: the same ramp with in_valid toggled 1010... -> identical output column sequence, and out_valid mirrors in_valid delayed by 1.
- Length mismatch: line_len=8 with in_eol at col 5 -> the line ends at col 5 and err_len=1. A following in_sof -> err_len=0.
- Back-to-back frames: new in_sof mid-row of a previous frame -> wr_sel=0, out_rows_ok=0, taps 1..N zero for row 0; a one-pixel line (sof+eol together) -> rows_seen=1.
- Async reset asserted mid-line 3 -> all outputs 0 immediately. After release, the first row's taps 1..N = 0 even though the RAM holds old data.
